sub_bytes_iter: RTL

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

---
 rtl/sub_bytes_iter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes over a 128-bit state.
// LANES S-boxes per cycle, valid/ready on both sides.
module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [127:0]   r_work;
  logic [127:0]   r_dout;
  logic [127:0]   w_work;
  logic           r_inv;
  logic           w_last;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b,
    input logic       iv
  );
    logic [7:0] y;
    if (!iv) begin
      y = ginv(b);
      return y ^ rotl(y, 1) ^ rotl(y, 2)
           ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    end
    y = rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    return ginv(y);
  endfunction

  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_work = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work[127 - 8*(int'(r_cnt)*LANES + l) -: 8] =
        sbox(r_work[127 - 8*(int'(r_cnt)*LANES + l) -: 8], r_inv);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_dout <= '0;
      r_inv  <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_work <= data_in;
      r_inv  <= inv;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_work <= w_work;
      // result register is separate so it survives the next accept
      if (w_last) r_dout <= w_work;
      else        r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign data_out  = r_dout;

endmodule
